// File: rtl/Purple_Jade_pkg.sv
// Shared core types: machine widths, CDB broadcast layout and the
// multiply reservation-station entry format.
package Purple_Jade_pkg;

  localparam int unsigned WORD_SIZE_P   = 32;
  localparam int unsigned ROB_ENTRY     = 16;
  localparam int unsigned NUM_PHYS_REG  = 64;
  localparam int unsigned ROB_W         = $clog2(ROB_ENTRY);
  localparam int unsigned PREG_W        = $clog2(NUM_PHYS_REG);
  localparam int unsigned CDB_FLAG_W    = 2;
  localparam int unsigned RS_MULT_DEPTH = 4;

  typedef struct packed {
    logic                   valid;
    logic [PREG_W-1:0]      dest;
    logic [CDB_FLAG_W-1:0]  flags;
    logic [WORD_SIZE_P-1:0] result;
  } cdb_t;

  localparam int unsigned CDB_WIDTH = $bits(cdb_t);

  typedef struct packed {
    logic                   rdy;
    logic [PREG_W-1:0]      tag;
    logic [WORD_SIZE_P-1:0] val;
  } mult_rs_src_t;

  typedef struct packed {
    logic               valid;
    logic [ROB_W-1:0]   rob_dest;
    logic [PREG_W-1:0]  reg_dest;
    mult_rs_src_t [1:0] src;
  } mult_rs_entry_t;

endpackage

// File: rtl/mult_rs_select.sv
// Priority picker: grants the lowest-index ready entry (the oldest one,
// since the station is kept age-ordered).
module mult_rs_select
  import Purple_Jade_pkg::*;
#(
  parameter int unsigned RS_DEPTH = RS_MULT_DEPTH
) (
  input  logic [RS_DEPTH-1:0] ready_vec,
  output logic [RS_DEPTH-1:0] grant,
  output logic                any_v
);

  // first set bit from index 0 upward wins
  always_comb begin
    grant = '0;
    any_v = 1'b0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (ready_vec[i] && !any_v) begin
        grant[i] = 1'b1;
        any_v    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_rs.sv
// Multiply reservation station: compacting age-ordered queue with CDB
// wakeup, dispatch bypass, oldest-ready issue and mispredict flush.
module mult_rs
  import Purple_Jade_pkg::*;
#(
  parameter int unsigned RS_DEPTH = RS_MULT_DEPTH,
  parameter int unsigned NUM_CDB  = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        disp_v_i,
  output logic                        disp_ready_o,
  input  logic [ROB_W-1:0]            disp_rob_dest_i,
  input  logic [PREG_W-1:0]           disp_reg_dest_i,
  input  logic [1:0]                  disp_src_rdy_i,
  input  logic [1:0][PREG_W-1:0]      disp_src_tag_i,
  input  logic [1:0][WORD_SIZE_P-1:0] disp_src_val_i,
  input  cdb_t [NUM_CDB-1:0]          cdb_i,
  output logic                        exe_v_o,
  output logic [WORD_SIZE_P-1:0]      operand1_o,
  output logic [WORD_SIZE_P-1:0]      operand2_o,
  output logic [ROB_W-1:0]            rob_dest_o,
  output logic [PREG_W-1:0]           reg_dest_o,
  input  logic                        mispredict_i
);

  mult_rs_entry_t              entry_q [RS_DEPTH];
  mult_rs_entry_t              entry_d [RS_DEPTH];
  mult_rs_entry_t              woken   [RS_DEPTH+1];
  mult_rs_entry_t              new_entry;
  mult_rs_entry_t              sel_entry;
  logic [RS_DEPTH-1:0]         rdy_vec;
  logic [RS_DEPTH-1:0]         grant;
  logic                        any_v;
  logic                        shift;
  logic                        placed;
  logic                        unused_bits;

  // Scan ports high-to-low so the lowest-index matching port is applied last.
  function automatic mult_rs_src_t snoop(input mult_rs_src_t s);
    snoop = s;
    if (!s.rdy) begin
      for (int unsigned p = NUM_CDB; p > 0; p--) begin
        if (cdb_i[p-1].valid && cdb_i[p-1].dest == s.tag) begin
          snoop.rdy = 1'b1;
          snoop.val = cdb_i[p-1].result;
        end
      end
    end
  endfunction

  // Queue stays compacted, so the top slot being valid means it is full.
  assign disp_ready_o = !entry_q[RS_DEPTH-1].valid;

  // issue candidates from start-of-cycle readiness only
  always_comb begin
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      rdy_vec[i] = entry_q[i].valid & entry_q[i].src[0].rdy & entry_q[i].src[1].rdy;
    end
  end

  mult_rs_select #(
    .RS_DEPTH(RS_DEPTH)
  ) u_select (
    .ready_vec(rdy_vec),
    .grant    (grant),
    .any_v    (any_v)
  );

  // mux out the granted entry for the output register
  always_comb begin
    sel_entry = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (grant[i]) sel_entry = entry_q[i];
    end
  end

  // Wakeup, then shift-down above the issued slot, then place dispatch in
  // the first free slot; woken[] carries an empty sentinel past the top.
  always_comb begin
    woken[RS_DEPTH] = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      woken[i]        = entry_q[i];
      woken[i].src[0] = snoop(entry_q[i].src[0]);
      woken[i].src[1] = snoop(entry_q[i].src[1]);
    end

    shift = 1'b0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      shift      = shift | grant[i];
      entry_d[i] = shift ? woken[i+1] : woken[i];
    end

    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.rob_dest = disp_rob_dest_i;
    new_entry.reg_dest = disp_reg_dest_i;
    for (int unsigned s = 0; s < 2; s++) begin
      new_entry.src[s] = snoop('{rdy: disp_src_rdy_i[s],
                                 tag: disp_src_tag_i[s],
                                 val: disp_src_val_i[s]});
    end

    placed = 1'b0;
    if (disp_v_i && disp_ready_o) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        if (!placed && !entry_d[i].valid) begin
          entry_d[i] = new_entry;
          placed     = 1'b1;
        end
      end
    end
  end

  // CDB flags and the issued entry's tag/ready bits carry no meaning here
  always_comb begin
    unused_bits = ^{sel_entry.valid, sel_entry.src[0].rdy, sel_entry.src[0].tag,
                    sel_entry.src[1].rdy, sel_entry.src[1].tag};
    for (int unsigned p = 0; p < NUM_CDB; p++) begin
      unused_bits = unused_bits ^ (^cdb_i[p].flags);
    end
  end

  // entry storage and issue output register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) entry_q[i] <= '0;
      exe_v_o    <= 1'b0;
      operand1_o <= '0;
      operand2_o <= '0;
      rob_dest_o <= '0;
      reg_dest_o <= '0;
    end else if (mispredict_i) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) entry_q[i].valid <= 1'b0;
      exe_v_o <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) entry_q[i] <= entry_d[i];
      exe_v_o <= any_v;
      if (any_v) begin
        operand1_o <= sel_entry.src[0].val;
        operand2_o <= sel_entry.src[1].val;
        rob_dest_o <= sel_entry.rob_dest;
        reg_dest_o <= sel_entry.reg_dest;
      end
    end
  end

endmodule

// File: tb/tb_mult_rs.sv
// Bench for mult_rs: directed scenarios followed by random traffic, all
// checked against a queue-based behavioural model of the station.
module tb_mult_rs;
  import Purple_Jade_pkg::*;

  localparam int unsigned DEPTH = RS_MULT_DEPTH;
  localparam int unsigned NCDB  = 2;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic                        disp_v;
  logic                        disp_ready;
  logic [ROB_W-1:0]            disp_rob;
  logic [PREG_W-1:0]           disp_reg;
  logic [1:0]                  disp_rdy;
  logic [1:0][PREG_W-1:0]      disp_tag;
  logic [1:0][WORD_SIZE_P-1:0] disp_val;
  cdb_t [NCDB-1:0]             cdb;
  logic                        exe_v;
  logic [WORD_SIZE_P-1:0]      op1, op2;
  logic [ROB_W-1:0]            rob_dest;
  logic [PREG_W-1:0]           reg_dest;
  logic                        mispredict;

  always #5 clk = ~clk;

  mult_rs #(
    .RS_DEPTH(DEPTH),
    .NUM_CDB (NCDB)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .disp_v_i       (disp_v),
    .disp_ready_o   (disp_ready),
    .disp_rob_dest_i(disp_rob),
    .disp_reg_dest_i(disp_reg),
    .disp_src_rdy_i (disp_rdy),
    .disp_src_tag_i (disp_tag),
    .disp_src_val_i (disp_val),
    .cdb_i          (cdb),
    .exe_v_o        (exe_v),
    .operand1_o     (op1),
    .operand2_o     (op2),
    .rob_dest_o     (rob_dest),
    .reg_dest_o     (reg_dest),
    .mispredict_i   (mispredict)
  );

  typedef struct packed {
    logic [ROB_W-1:0]            rob;
    logic [PREG_W-1:0]           rd;
    logic [1:0]                  rdy;
    logic [1:0][PREG_W-1:0]      tag;
    logic [1:0][WORD_SIZE_P-1:0] val;
  } ment_t;

  ment_t                  mq[$];
  logic                   m_exe_v;
  logic [WORD_SIZE_P-1:0] m_op1, m_op2;
  logic [ROB_W-1:0]       m_rob;
  logic [PREG_W-1:0]      m_rd;
  int                     vectors = 0;
  int                     miscompares = 0;
  bit                     checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // lowest-numbered CDB port carrying this tag supplies the value
  function automatic bit cdb_hit(input logic [PREG_W-1:0] t, output logic [WORD_SIZE_P-1:0] v);
    v = '0;
    for (int p = 0; p < NCDB; p++) begin
      if (cdb[p].valid && cdb[p].dest == t) begin
        v = cdb[p].result;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check_outputs();
    chk("exe_v", 64'(exe_v), 64'(m_exe_v));
    chk("disp_ready", 64'(disp_ready), 64'(mq.size() < DEPTH));
    chk("operand1", 64'(op1), 64'(m_op1));
    chk("operand2", 64'(op2), 64'(m_op2));
    chk("rob_dest", 64'(rob_dest), 64'(m_rob));
    chk("reg_dest", 64'(reg_dest), 64'(m_rd));
  endtask

  // one clock edge of the behavioural model, from the inputs now applied
  task automatic model_step();
    int                     sel;
    bit                     accept;
    ment_t                  e;
    logic [WORD_SIZE_P-1:0] v;
    if (!reset_n) begin
      mq.delete();
      m_exe_v = 1'b0; m_op1 = '0; m_op2 = '0; m_rob = '0; m_rd = '0;
      return;
    end
    if (mispredict) begin
      mq.delete();
      m_exe_v = 1'b0;
      return;
    end
    accept = disp_v && (mq.size() < DEPTH);
    sel = -1;
    for (int i = 0; i < mq.size(); i++)
      if (sel < 0 && mq[i].rdy == 2'b11) sel = i;
    m_exe_v = (sel >= 0);
    if (sel >= 0) begin
      m_op1 = mq[sel].val[0];
      m_op2 = mq[sel].val[1];
      m_rob = mq[sel].rob;
      m_rd  = mq[sel].rd;
      mq.delete(sel);
    end
    for (int i = 0; i < mq.size(); i++)
      for (int s = 0; s < 2; s++)
        if (!mq[i].rdy[s] && cdb_hit(mq[i].tag[s], v)) begin
          mq[i].rdy[s] = 1'b1;
          mq[i].val[s] = v;
        end
    if (accept) begin
      e.rob = disp_rob; e.rd = disp_reg; e.rdy = disp_rdy;
      e.tag = disp_tag; e.val = disp_val;
      for (int s = 0; s < 2; s++)
        if (!e.rdy[s] && cdb_hit(e.tag[s], v)) begin
          e.rdy[s] = 1'b1;
          e.val[s] = v;
        end
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    if (checking) check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_v = 1'b0; disp_rob = '0; disp_reg = '0; disp_rdy = '0;
    disp_tag = '0; disp_val = '0; cdb = '0; mispredict = 1'b0;
  endtask

  task automatic disp(input int rob, input int rd, input logic [1:0] rdy,
                      input int t1, input int v1, input int t2, input int v2);
    disp_v = 1'b1;
    disp_rob = ROB_W'(rob);
    disp_reg = PREG_W'(rd);
    disp_rdy = rdy;
    disp_tag[0] = PREG_W'(t1); disp_val[0] = WORD_SIZE_P'(v1);
    disp_tag[1] = PREG_W'(t2); disp_val[1] = WORD_SIZE_P'(v2);
  endtask

  task automatic bcast(input int port, input int dest, input logic [WORD_SIZE_P-1:0] res);
    cdb[port].valid  = 1'b1;
    cdb[port].dest   = PREG_W'(dest);
    cdb[port].flags  = 2'b11;
    cdb[port].result = res;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    checking = 1'b1;

    // reset state
    chk("rst_exe_v", 64'(exe_v), 0);
    chk("rst_op1", 64'(op1), 0);
    chk("rst_op2", 64'(op2), 0);
    chk("rst_rob", 64'(rob_dest), 0);
    chk("rst_reg", 64'(reg_dest), 0);
    chk("rst_ready", 64'(disp_ready), 1);

    // basic issue: dispatch in N, output in N+2
    disp(2, 9, 2'b11, 0, 3, 0, 5); tick();
    idle(); tick();
    chk("basic_v", 64'(exe_v), 1);
    chk("basic_op1", 64'(op1), 3);
    chk("basic_op2", 64'(op2), 5);
    chk("basic_rob", 64'(rob_dest), 2);
    chk("basic_reg", 64'(reg_dest), 9);
    tick();

    // CDB wakeup on port 1
    disp(3, 10, 2'b01, 0, 4, 7, 0); tick();
    idle(); tick(); tick();
    chk("wait_v", 64'(exe_v), 0);
    bcast(1, 7, 6); tick();
    idle(); tick();
    chk("wake_v", 64'(exe_v), 1);
    chk("wake_op1", 64'(op1), 4);
    chk("wake_op2", 64'(op2), 6);
    tick();

    // same-cycle dispatch bypass
    disp(4, 11, 2'b01, 0, 1, 12, 0);
    bcast(0, 12, 32'hFFFF); tick();
    idle(); tick();
    chk("byp_v", 64'(exe_v), 1);
    chk("byp_op2", 64'(op2), 32'hFFFF);
    tick();

    // fill all entries waiting on tag 20, then wake them together
    for (int k = 0; k < 4; k++) begin
      disp(5 + k, 20 + k, 2'b01, 0, k + 1, 20, 0); tick();
    end
    idle();
    chk("full_ready", 64'(disp_ready), 0);
    bcast(0, 20, 100); tick();
    idle();
    disp(15, 1, 2'b11, 0, 1, 0, 1);  // offered while full: must be dropped
    chk("full_ready_issue", 64'(disp_ready), 0);
    tick();
    idle();
    chk("ready_back", 64'(disp_ready), 1);
    for (int k = 0; k < 4; k++) begin
      chk("order_v", 64'(exe_v), 1);
      chk("order_rob", 64'(rob_dest), 64'(5 + k));
      tick();
    end
    chk("drained_v", 64'(exe_v), 0);

    // out-of-order readiness
    disp(1, 30, 2'b01, 0, 2, 33, 0); tick();
    disp(2, 31, 2'b11, 0, 7, 0, 8); tick();
    idle(); tick();
    chk("ooo_first", 64'(rob_dest), 2);
    bcast(1, 33, 9); tick();
    idle(); tick();
    chk("ooo_second", 64'(rob_dest), 1);
    chk("ooo_op2", 64'(op2), 9);
    tick();

    // flush with issue in flight and a concurrent dispatch
    for (int k = 0; k < 3; k++) begin
      disp(6 + k, 40 + k, 2'b01, 0, 0, 40, 0); tick();
    end
    disp(9, 44, 2'b11, 0, 1, 0, 1); tick();
    disp(10, 45, 2'b11, 0, 2, 0, 2);
    mispredict = 1'b1; tick();
    idle();
    chk("flush_v", 64'(exe_v), 0);
    chk("flush_ready", 64'(disp_ready), 1);
    bcast(0, 40, 5); tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      chk("flush_quiet", 64'(exe_v), 0);
      tick();
    end

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        disp($urandom_range(0, 15), $urandom_range(0, 63), 2'($urandom_range(0, 3)),
             $urandom_range(0, 7), int'($urandom), $urandom_range(0, 7), int'($urandom));
      for (int p = 0; p < NCDB; p++)
        if ($urandom_range(0, 1) == 1) bcast(p, $urandom_range(0, 7), $urandom);
      mispredict = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle();
    for (int n = 0; n < 8; n++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
